// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interrupt sequencer.
// State encoding, level/vector constants and a 3-to-8 one-hot helper.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PENDING = 2'b01,
        ACK1    = 2'b10
    } pic_state_e;

    localparam int NUM_LEVELS     = 8;
    localparam int SPURIOUS_LEVEL = 7;
    localparam int VEC_BASE_MSB   = 7;
    localparam int VEC_BASE_LSB   = 3;

    function automatic logic [7:0] onehot3to8(input logic [2:0] lvl);
        return 8'b1 << lvl;
    endfunction

endpackage

// File: rtl/interrupt_sequence_controller_if.sv
// Bus bundle between the sequencer and its IRR / CPU-buffer neighbours.
// slave: the sequencer side; master: the driver (IRR, command decode, CPU).
interface interrupt_sequence_controller_if;

    logic [7:0] irr;
    logic [7:0] icw2;
    logic       aeoi;
    logic       inta;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] clear_irr;
    logic [7:0] vector_out;
    logic       vector_valid;
    logic [1:0] state_out;

    modport slave (
        input  irr, icw2, aeoi, inta,
        input  eoi_valid, eoi_specific, eoi_level,
        output int_out, isr, clear_irr,
        output vector_out, vector_valid, state_out
    );

    modport master (
        output irr, icw2, aeoi, inta,
        output eoi_valid, eoi_specific, eoi_level,
        input  int_out, isr, clear_irr,
        input  vector_out, vector_valid, state_out
    );

endinterface

// File: rtl/pic_priority_encoder.sv
// Fully-nested fixed-priority resolver (IR0 highest) plus lowest set ISR bit.
// Ports: req, in_service in; valid, winner, isr_low out.
module pic_priority_encoder
    import pic_pkg::*;
(
    input  logic [7:0] req,
    input  logic [7:0] in_service,
    output logic       valid,
    output logic [2:0] winner,
    output logic [2:0] isr_low
);

    logic blocked;

    // An in-service bit blocks its own level and everything below it.
    always_comb begin
        valid   = 1'b0;
        winner  = 3'd0;
        blocked = 1'b0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (in_service[i]) blocked = 1'b1;
            if (!blocked && !valid && req[i]) begin
                valid  = 1'b1;
                winner = 3'(i);
            end
        end
    end

    // Meaningless when in_service is zero; the caller masks with isr.
    always_comb begin
        isr_low = 3'd0;
        for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
            if (in_service[i]) isr_low = 3'(i);
        end
    end

endmodule

// File: rtl/interrupt_sequence_controller.sv
// PIC interrupt sequencer: arbitration, INTA handshake, ISR, EOI, vector.
// Ports: clk, reset (sync, active-high), bus (slave modport of the _if).
module interrupt_sequence_controller
    import pic_pkg::*;
#(
    parameter int NUM_LEVELS_P     = NUM_LEVELS,
    parameter int SPURIOUS_LEVEL_P = SPURIOUS_LEVEL
) (
    input  logic                                 clk,
    input  logic                                 reset,
    interrupt_sequence_controller_if.slave       bus
);

    pic_state_e              state_q, state_d;
    logic                    int_q, int_d;
    logic [NUM_LEVELS_P-1:0] isr_q, isr_d;
    logic [7:0]              clr_q, clr_d;
    logic [7:0]              vec_q, vec_d;
    logic                    vv_q, vv_d;
    logic [2:0]              lvl_q, lvl_d;
    logic                    spur_q, spur_d;

    logic       arb_valid;
    logic [2:0] arb_winner;
    logic [2:0] isr_low;
    logic [7:0] set_mask;
    logic [7:0] aeoi_mask;
    logic [7:0] eoi_mask;

    pic_priority_encoder u_prio (
        .req        (bus.irr),
        .in_service (isr_q),
        .valid      (arb_valid),
        .winner     (arb_winner),
        .isr_low    (isr_low)
    );

    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        lvl_d     = lvl_q;
        spur_d    = spur_q;
        vec_d     = vec_q;
        vv_d      = 1'b0;
        clr_d     = 8'h00;
        set_mask  = 8'h00;
        aeoi_mask = 8'h00;
        eoi_mask  = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = PENDING;
                    int_d   = 1'b1;
                end
            end
            PENDING: begin
                if (bus.inta) begin
                    state_d = ACK1;
                    int_d   = 1'b0;
                    if (arb_valid) begin
                        lvl_d    = arb_winner;
                        spur_d   = 1'b0;
                        set_mask = onehot3to8(arb_winner);
                        clr_d    = set_mask;
                    end else begin
                        lvl_d  = 3'(SPURIOUS_LEVEL_P);
                        spur_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (bus.inta) begin
                    state_d = IDLE;
                    vv_d    = 1'b1;
                    vec_d   = {bus.icw2[VEC_BASE_MSB:VEC_BASE_LSB], lvl_q};
                    if (bus.aeoi && !spur_q) aeoi_mask = onehot3to8(lvl_q);
                end
            end
            default: state_d = IDLE;
        endcase

        // Non-specific picks from the pre-update isr; no set bit -> no effect.
        if (bus.eoi_valid) begin
            eoi_mask = bus.eoi_specific ? onehot3to8(bus.eoi_level)
                                        : onehot3to8(isr_low);
        end

        // Set is applied last so it wins over a same-bit EOI.
        isr_d = (isr_q & ~(eoi_mask | aeoi_mask)) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
            isr_q   <= '0;
            clr_q   <= 8'h00;
            vec_q   <= 8'h00;
            vv_q    <= 1'b0;
            lvl_q   <= 3'd0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            isr_q   <= isr_d;
            clr_q   <= clr_d;
            vec_q   <= vec_d;
            vv_q    <= vv_d;
            lvl_q   <= lvl_d;
            spur_q  <= spur_d;
        end
    end

    assign bus.int_out      = int_q;
    assign bus.isr          = isr_q;
    assign bus.clear_irr    = clr_q;
    assign bus.vector_out   = vec_q;
    assign bus.vector_valid = vv_q;
    assign bus.state_out    = state_q;

endmodule

// File: tb/tb_interrupt_sequence_controller.sv
// Self-checking bench for interrupt_sequence_controller.
// Expected vectors are queued at the second INTA and popped on vector_valid.
module tb_interrupt_sequence_controller;

    logic clk = 1'b0;
    logic reset;

    interrupt_sequence_controller_if sif ();

    interrupt_sequence_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] model_vec(input logic [7:0] b, input logic [2:0] l);
        return {b[7:3], l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inta_pulse();
        sif.inta = 1'b1;
        tick();
        sif.inta = 1'b0;
    endtask

    task automatic second_inta(input logic [2:0] lvl);
        exp_q.push_back(model_vec(sif.icw2, lvl));
        inta_pulse();
    endtask

    // Scoreboard: every vector_valid must match the oldest queued vector.
    always @(negedge clk) begin
        if (sif.vector_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL vec_unexpected: got %h want none", sif.vector_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (sif.vector_out !== e) begin
                    n_bad++;
                    $display("FAIL vector: got %h want %h", sif.vector_out, e);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({sif.state_out, sif.int_out, sif.isr, sif.clear_irr,
             sif.vector_out, sif.vector_valid} !== 28'h0) begin
            n_bad++;
            $display("FAIL reset: st=%0d int=%b isr=%h clr=%h vec=%h vv=%b want all 0",
                     sif.state_out, sif.int_out, sif.isr, sif.clear_irr,
                     sif.vector_out, sif.vector_valid);
        end
    endtask

    task automatic test_basic();
        sif.icw2 = 8'h40;
        sif.irr  = 8'h08;
        tick();
        n_cmp++;
        if (sif.int_out !== 1'b1 || sif.state_out !== 2'd1) begin
            n_bad++;
            $display("FAIL basic_int: int=%b st=%0d want 1/1", sif.int_out, sif.state_out);
        end
        inta_pulse();
        sif.irr = 8'h00;
        n_cmp++;
        if (sif.isr !== 8'h08 || sif.clear_irr !== 8'h08 || sif.int_out !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_ack1: isr=%h clr=%h int=%b want 08/08/0",
                     sif.isr, sif.clear_irr, sif.int_out);
        end
        tick();
        n_cmp++;
        if (sif.clear_irr !== 8'h00 || sif.state_out !== 2'd2) begin
            n_bad++;
            $display("FAIL basic_clr_pulse: clr=%h st=%0d want 00/2",
                     sif.clear_irr, sif.state_out);
        end
        second_inta(3'd3);
        tick();
        n_cmp++;
        if (sif.vector_valid !== 1'b0 || sif.vector_out !== 8'h43) begin
            n_bad++;
            $display("FAIL basic_hold: vv=%b vec=%h want 0/43",
                     sif.vector_valid, sif.vector_out);
        end
        sif.eoi_valid = 1'b1;
        tick();
        sif.eoi_valid = 1'b0;
        tick();
    endtask

    task automatic test_nesting();
        sif.irr = 8'h24;
        tick();
        inta_pulse();
        sif.irr = 8'h20;
        n_cmp++;
        if (sif.isr !== 8'h04 || sif.clear_irr !== 8'h04) begin
            n_bad++;
            $display("FAIL nest_first: isr=%h clr=%h want 04/04", sif.isr, sif.clear_irr);
        end
        tick();
        second_inta(3'd2);
        tick();
        tick();
        tick();
        n_cmp++;
        if (sif.int_out !== 1'b0 || sif.state_out !== 2'd0) begin
            n_bad++;
            $display("FAIL nest_blocked: int=%b st=%0d want 0/0", sif.int_out, sif.state_out);
        end
        sif.irr = 8'h21;
        tick();
        n_cmp++;
        if (sif.int_out !== 1'b1) begin
            n_bad++;
            $display("FAIL nest_raise: int=%b want 1", sif.int_out);
        end
        inta_pulse();
        sif.irr = 8'h00;
        n_cmp++;
        if (sif.isr !== 8'h05 || sif.clear_irr !== 8'h01) begin
            n_bad++;
            $display("FAIL nest_isr: isr=%h clr=%h want 05/01", sif.isr, sif.clear_irr);
        end
        tick();
        second_inta(3'd0);
        tick();
    endtask

    task automatic test_eoi();
        logic [7:0] want[3];
        logic       spec[3];
        logic [2:0] lvl[3];
        want = '{8'h04, 8'h04, 8'h00};
        spec = '{1'b0, 1'b1, 1'b1};
        lvl  = '{3'd5, 3'd3, 3'd2};
        for (int i = 0; i < 3; i++) begin
            sif.eoi_valid    = 1'b1;
            sif.eoi_specific = spec[i];
            sif.eoi_level    = lvl[i];
            tick();
            sif.eoi_valid = 1'b0;
            n_cmp++;
            if (sif.isr !== want[i]) begin
                n_bad++;
                $display("FAIL eoi_%0d: isr=%h want %h", i, sif.isr, want[i]);
            end
        end
        sif.eoi_specific = 1'b0;
    endtask

    task automatic test_spurious();
        sif.irr = 8'h02;
        tick();
        sif.irr = 8'h00;
        tick();
        n_cmp++;
        if (sif.int_out !== 1'b1) begin
            n_bad++;
            $display("FAIL spur_hold: int=%b want 1", sif.int_out);
        end
        inta_pulse();
        n_cmp++;
        if (sif.isr !== 8'h00 || sif.clear_irr !== 8'h00 || sif.state_out !== 2'd2) begin
            n_bad++;
            $display("FAIL spur_ack1: isr=%h clr=%h st=%0d want 00/00/2",
                     sif.isr, sif.clear_irr, sif.state_out);
        end
        second_inta(3'd7);
        tick();
    endtask

    task automatic test_aeoi();
        sif.aeoi = 1'b1;
        sif.icw2 = 8'hA5;
        sif.irr  = 8'h80;
        tick();
        inta_pulse();
        sif.irr = 8'h00;
        n_cmp++;
        if (sif.isr !== 8'h80) begin
            n_bad++;
            $display("FAIL aeoi_set: isr=%h want 80", sif.isr);
        end
        tick();
        second_inta(3'd7);
        n_cmp++;
        if (sif.isr !== 8'h00 || sif.vector_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL aeoi_clear: isr=%h vv=%b want 00/1", sif.isr, sif.vector_valid);
        end
        sif.aeoi = 1'b0;
        tick();
    endtask

    task automatic test_boundaries();
        sif.irr = 8'h10;
        tick();
        sif.inta         = 1'b1;
        sif.eoi_valid    = 1'b1;
        sif.eoi_specific = 1'b1;
        sif.eoi_level    = 3'd4;
        tick();
        sif.inta      = 1'b0;
        sif.eoi_valid = 1'b0;
        sif.irr       = 8'h00;
        n_cmp++;
        if (sif.isr !== 8'h10) begin
            n_bad++;
            $display("FAIL set_beats_eoi: isr=%h want 10", sif.isr);
        end
        second_inta(3'd4);
        sif.eoi_valid = 1'b1;
        tick();
        sif.eoi_valid = 1'b0;
        n_cmp++;
        if (sif.isr !== 8'h00) begin
            n_bad++;
            $display("FAIL eoi_after: isr=%h want 00", sif.isr);
        end
        sif.irr = 8'h02;
        tick();
        inta_pulse();
        sif.irr = 8'h00;
        sif.inta = 1'b1;
        reset    = 1'b1;
        tick();
        sif.inta = 1'b0;
        reset    = 1'b0;
        n_cmp++;
        if (sif.state_out !== 2'd0 || sif.isr !== 8'h00 ||
            sif.int_out !== 1'b0 || sif.vector_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ack1: st=%0d isr=%h int=%b vv=%b want 0/00/0/0",
                     sif.state_out, sif.isr, sif.int_out, sif.vector_valid);
        end
        tick();
        tick();
    endtask

    initial begin
        reset            = 1'b1;
        sif.irr          = 8'h00;
        sif.icw2         = 8'h00;
        sif.aeoi         = 1'b0;
        sif.inta         = 1'b0;
        sif.eoi_valid    = 1'b0;
        sif.eoi_specific = 1'b0;
        sif.eoi_level    = 3'd0;
        test_reset();
        test_basic();
        test_nesting();
        test_eoi();
        test_spurious();
        test_aeoi();
        test_boundaries();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL vec_missing: %0d queued want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interrupt_sequence_controller.md
Name: interrupt_sequence_controller

Overview:
Clocked sequencer for the PIC's interrupt path. It sits between the Interrupt Request Register and the CPU-side data buffer.
- Resolves fixed priority (IR0 highest) over masked IRR requests and raises INT.
- Runs the two-pulse INTA handshake and maintains the In-Service Register (ISR).
- Issues one-hot clear pulses back to the IRR and produces the 8-bit vector.
- Services specific/non-specific EOI and automatic EOI.

Parameters:
NUM_LEVELS, 8, number of IR levels; only 8 is supported.
SPURIOUS_LEVEL, 7, level reported when no request is eligible at the first INTA.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
irr  input  8  pending requests, already masked by IMR; bit n = IRn
icw2  input  8  vector base; bits[7:3] used
aeoi  input  1  automatic-EOI mode enable (from ICW4)
inta  input  1  one-cycle strobe per CPU INTA pulse, already synchronised
eoi_valid  input  1  one-cycle strobe: EOI command received (OCW2)
eoi_specific  input  1  1 = specific EOI using eoi_level; 0 = non-specific
eoi_level  input  3  level cleared by a specific EOI
int_out  output  1  interrupt request to CPU
isr  output  8  In-Service Register
clear_irr  output  8  one-hot, one-cycle pulse clearing the serviced IRR bit
vector_out  output  8  interrupt vector {icw2[7:3], level}
vector_valid  output  1  one-cycle strobe; vector_out is valid
state_out  output  2  current FSM state, for debug and verification

Behaviour:
- Reset (synchronous, active-high; takes priority over everything, including mid-handshake):
  - state = IDLE.
  - int_out = 0, isr = 0, clear_irr = 0, vector_out = 0, vector_valid = 0.
- Eligibility: level L is eligible iff irr[L] = 1 and isr[k] = 0 for all k <= L (fully nested). Winner = lowest eligible index.
- States: IDLE (00), PENDING (01), ACK1 (10).
- IDLE:
  - If any level is eligible, go to PENDING; int_out = 1 from the next cycle (1-cycle latency).
  - inta in IDLE is ignored.
- PENDING:
  - int_out held at 1 until the first inta, even if the request drops.
  - On inta, the winner is sampled that cycle. Next cycle:
    - isr[winner] = 1 and clear_irr = onehot(winner) for exactly one cycle.
    - int_out = 0; state = ACK1; the level is latched.
  - If nothing is eligible at inta (spurious): latch SPURIOUS_LEVEL, set no ISR bit, issue no clear_irr pulse, go to ACK1.
- ACK1:
  - On the second inta, next cycle:
    - vector_out = {icw2[7:3], latched level}; vector_valid = 1 for one cycle.
    - If aeoi = 1 and the cycle was non-spurious, clear isr[latched level] in the same cycle.
    - state = IDLE.
  - vector_out then holds until the next vector.
  - Further inta in ACK1 before the second pulse: not applicable; extra pulses in IDLE are ignored.
- Re-arbitration: from IDLE the next cycle, using the updated isr.
- EOI (accepted in any state; takes effect the next cycle):
  - Non-specific: clears the lowest-index set bit of isr.
  - Specific: clears isr[eoi_level].
  - EOI with no matching set bit: no effect, no error.
- Simultaneous ISR set (PENDING->ACK1) and EOI in the same cycle:
  - EOI is evaluated against the pre-update isr.
  - If both target the same bit, the set wins.
- Simultaneous AEOI clear and EOI: both clears are applied (OR of clear masks).
- Lower-priority request while a higher level is in service: not eligible, so int_out stays 0.
- Higher-priority request while a lower level is in service: eligible, so it nests.

Decomposition:
- Shared package pic_pkg:
  - state enum {IDLE, PENDING, ACK1} with 2-bit encoding.
  - constants NUM_LEVELS = 8, SPURIOUS_LEVEL = 7, VEC_BASE_MSB = 7, VEC_BASE_LSB = 3.
  - function onehot3to8.
- One sub-module: pic_priority_encoder, combinational.
  - Inputs: 8-bit request, 8-bit in-service.
  - Outputs: valid, 3-bit winner, lowest-set-ISR index.
  - Used for both arbitration and non-specific EOI.

Test Plan:
1. Basic handshake:
   - Stimulus: reset, irr = 8'h08, icw2 = 8'h40, aeoi = 0.
   - Response: int_out = 1 one cycle later. First inta gives isr = 8'h08, clear_irr = 8'h08 (1 cycle), int_out = 0. Second inta gives vector_out = 8'h43 with vector_valid pulse.
2. Priority and nesting:
   - Stimulus: irr = 8'h24.
   - Response: level 2 is serviced first (isr = 8'h04). With irr = 8'h20 remaining, int_out stays 0. Later irr = 8'h21 gives a level-0 nest: isr = 8'h05, vector = base|0.
3. EOI variants:
   - Stimulus: isr = 8'h05; non-specific EOI, then specific EOI with eoi_level = 3, then specific EOI with eoi_level = 2.
   - Response: non-specific gives isr = 8'h04. Specific level 3 gives isr = 8'h04 (no effect). Specific level 2 gives isr = 8'h00.
4. Spurious:
   - Stimulus: irr = 8'h02 raises int_out; irr drops to 0 before the first inta.
   - Response: isr stays 8'h00, clear_irr stays 0, second inta gives vector_out = icw2[7:3]|7.
5. AEOI:
   - Stimulus: aeoi = 1, irr = 8'h80, two inta pulses.
   - Response: isr = 8'h80 after the first pulse, and 8'h00 in the same cycle as vector_valid.
6. Boundaries:
   - Same-cycle check: EOI for level 4 in the cycle the FSM enters ACK1 setting level 4 leaves isr[4] = 1.
   - Reset check: reset asserted in ACK1 gives state IDLE, isr = 0, int_out = 0, and no vector_valid.
